// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write path.
// DATA_W/ADDR_W/NUM_REGS describe the 16x16 register file; wb_entry_t is one
// queued writeback {destination index, data}.
package regfile_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  // 'reg' is a keyword, so the index field is called dst.
  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_queue.sv
// In-order writeback queue: circular buffer, up to two pushes and one pop per
// cycle, occupancy count and a per-slot valid vector for forwarding lookups.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   push_a, a_reg, a_data  first push (lands at tail)
//   push_b, b_reg, b_data  second push (tail+1 when push_a, else tail)
//   pop                    retire head entry at this edge
//   count, head            occupancy and head slot
//   ent_reg, ent_data      raw slot contents
//   valid                  slot holds a live entry
module wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int AW     = 4,
  parameter int DW     = 16,
  parameter int PW     = $clog2(DEPTH),
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push_a,
  input  logic [AW-1:0]             a_reg,
  input  logic [DW-1:0]             a_data,
  input  logic                      push_b,
  input  logic [AW-1:0]             b_reg,
  input  logic [DW-1:0]             b_data,
  input  logic                      pop,
  output logic [CW-1:0]             count,
  output logic [PW-1:0]             head,
  output logic [DEPTH-1:0][AW-1:0]  ent_reg,
  output logic [DEPTH-1:0][DW-1:0]  ent_data,
  output logic [DEPTH-1:0]          valid
);

  logic [PW-1:0] tail;
  logic [PW-1:0] b_slot;

  assign b_slot = push_a ? tail + PW'(1) : tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      head  <= '0;
      tail  <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(push_a) + PW'(push_b);
      count <= count - CW'(pop) + CW'(push_a) + CW'(push_b);
    end
  end

  // Storage is not reset; contents are only observed through valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_a) begin
        ent_reg[tail]  <= a_reg;
        ent_data[tail] <= a_data;
      end
      if (push_b) begin
        ent_reg[b_slot]  <= b_reg;
        ent_data[b_slot] <= b_data;
      end
    end
  end

  // A slot is live when its distance from head is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_valid
    logic [PW-1:0] off;
    assign off      = PW'(i) - head;
    assign valid[i] = {1'b0, off} < count;
  end

endmodule

// File: rtl/regfile_write_sequencer.sv
// Write-side front end of the register file. Arbitrates ALU and load
// writebacks into an in-order queue, drains one entry per cycle onto the
// single write port and offers two forwarding lookups into the queue.
// Ports:
//   clk, rst                                   clock, sync active-high reset
//   alu_valid/alu_reg/alu_data/alu_ready       ALU writeback handshake
//   mem_valid/mem_reg/mem_data/mem_ready       load writeback handshake
//   dst_reg/dst_data/write_reg                 register file write port
//   fwd_reg1/fwd_hit1/fwd_data1                forwarding lookup, read port 1
//   fwd_reg2/fwd_hit2/fwd_data2                forwarding lookup, read port 2
//   count                                      queue occupancy
module regfile_write_sequencer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_valid,
  input  logic [ADDR_W-1:0]          alu_reg,
  input  logic [DATA_W-1:0]          alu_data,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [ADDR_W-1:0]          mem_reg,
  input  logic [DATA_W-1:0]          mem_data,
  output logic                       mem_ready,
  output logic [ADDR_W-1:0]          dst_reg,
  output logic [DATA_W-1:0]          dst_data,
  output logic                       write_reg,
  input  logic [ADDR_W-1:0]          fwd_reg1,
  output logic                       fwd_hit1,
  output logic [DATA_W-1:0]          fwd_data1,
  input  logic [ADDR_W-1:0]          fwd_reg2,
  output logic                       fwd_hit2,
  output logic [DATA_W-1:0]          fwd_data2,
  output logic [$clog2(DEPTH):0]     count
);
  import regfile_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0]                  head;
  logic [DEPTH-1:0][ADDR_W-1:0]   ent_reg;
  logic [DEPTH-1:0][DATA_W-1:0]   ent_data;
  logic [DEPTH-1:0]               valid;
  logic [CW-1:0]                  free;
  logic                           pop;
  logic                           mem_acc;
  logic                           alu_acc;

  // Draining never stalls, so the head slot is always reusable this cycle.
  assign pop       = (count != '0);
  assign free      = CW'(DEPTH) - count + CW'(pop);
  assign mem_ready = (free >= CW'(1));
  assign alu_ready = (free >= CW'(1) + CW'(mem_valid));
  assign mem_acc   = mem_valid & mem_ready;
  assign alu_acc   = alu_valid & alu_ready;

  // Load goes first so a same-cycle ALU write to the same index wins.
  wb_queue #(
    .DEPTH (DEPTH),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push_a   (mem_acc),
    .a_reg    (mem_reg),
    .a_data   (mem_data),
    .push_b   (alu_acc),
    .b_reg    (alu_reg),
    .b_data   (alu_data),
    .pop      (pop),
    .count    (count),
    .head     (head),
    .ent_reg  (ent_reg),
    .ent_data (ent_data),
    .valid    (valid)
  );

  assign write_reg = pop;
  assign dst_reg   = pop ? ent_reg[head]  : '0;
  assign dst_data  = pop ? ent_data[head] : '0;

  // Walk oldest to youngest so the last match is the youngest one.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    idx       = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && ent_reg[idx] == fwd_reg1) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = ent_data[idx];
      end
      if (valid[idx] && ent_reg[idx] == fwd_reg2) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = ent_data[idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed table of per-cycle vectors plus a randomized traffic phase checked
// against a queue model of the write stream and forwarding results.
module tb_regfile_write_sequencer;
  import regfile_pkg::*;

  logic        clk;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic [3:0]  alu_reg, mem_reg;
  logic [15:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic [3:0]  dst_reg;
  logic [15:0] dst_data;
  logic        write_reg;
  logic [3:0]  fwd_reg1, fwd_reg2;
  logic        fwd_hit1, fwd_hit2;
  logic [15:0] fwd_data1, fwd_data2;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  regfile_write_sequencer #(.DEPTH(4), .DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
    .dst_reg(dst_reg), .dst_data(dst_data), .write_reg(write_reg),
    .fwd_reg1(fwd_reg1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_reg2(fwd_reg2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mv;
    logic [3:0]  mr;
    logic [15:0] md;
    logic        av;
    logic [3:0]  ar;
    logic [15:0] ad;
    logic [3:0]  f1;
    logic [3:0]  f2;
    logic        wr;
    logic [3:0]  dr;
    logic [15:0] dd;
    logic [2:0]  cnt;
    logic        mrdy;
    logic        ardy;
    logic        h1;
    logic [15:0] d1;
    logic        h2;
    logic [15:0] d2;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, mv, input logic [3:0] mr, input logic [15:0] md,
    input logic av, input logic [3:0] ar, input logic [15:0] ad,
    input logic [3:0] f1, f2,
    input logic wr, input logic [3:0] dr, input logic [15:0] dd, input logic [2:0] cnt,
    input logic mrdy, ardy, h1, input logic [15:0] d1, input logic h2, input logic [15:0] d2);
    vec_t v;
    v.rst = r; v.mv = mv; v.mr = mr; v.md = md; v.av = av; v.ar = ar; v.ad = ad;
    v.f1 = f1; v.f2 = f2; v.wr = wr; v.dr = dr; v.dd = dd; v.cnt = cnt;
    v.mrdy = mrdy; v.ardy = ardy; v.h1 = h1; v.d1 = d1; v.h2 = h2; v.d2 = d2;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic wr, input logic [3:0] dr,
                            input logic [15:0] dd, input logic [2:0] cnt,
                            input logic mrdy, ardy, h1, input logic [15:0] d1,
                            input logic h2, input logic [15:0] d2);
    chk({tag, " write_reg"}, 32'(write_reg), 32'(wr));
    chk({tag, " dst_reg"},   32'(dst_reg),   32'(dr));
    chk({tag, " dst_data"},  32'(dst_data),  32'(dd));
    chk({tag, " count"},     32'(count),     32'(cnt));
    chk({tag, " mem_ready"}, 32'(mem_ready), 32'(mrdy));
    chk({tag, " alu_ready"}, 32'(alu_ready), 32'(ardy));
    chk({tag, " fwd_hit1"},  32'(fwd_hit1),  32'(h1));
    chk({tag, " fwd_data1"}, 32'(fwd_data1), 32'(d1));
    chk({tag, " fwd_hit2"},  32'(fwd_hit2),  32'(h2));
    chk({tag, " fwd_data2"}, 32'(fwd_data2), 32'(d2));
  endtask

  // Reference model of queued writes (oldest at index 0).
  wb_entry_t mq[$];

  initial begin
    rst = 1'b1; alu_valid = 0; mem_valid = 0; alu_reg = 0; mem_reg = 0;
    alu_data = 0; mem_data = 0; fwd_reg1 = 0; fwd_reg2 = 0;

    //        rst mv mr md       av ar ad       f1 f2 | wr dr dd       cnt mr ar h1 d1       h2 d2
    vecs.push_back(mk(1,0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0,16'h0000, 0,1,1, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000, 1,3,16'h1234, 0,0, 0,0,16'h0000, 0,1,1, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 3,0, 1,3,16'h1234, 1,1,1, 1,16'h1234, 0,16'h0000));
    vecs.push_back(mk(0,1,5,16'hAAAA, 1,5,16'hBBBB, 3,0, 0,0,16'h0000, 0,1,1, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 5,5, 1,5,16'hAAAA, 2,1,1, 1,16'hBBBB, 1,16'hBBBB));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 5,0, 1,5,16'hBBBB, 1,1,1, 1,16'hBBBB, 0,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0,16'h0000, 0,1,1, 0,16'h0000, 0,16'h0000));
    // sustained dual push fills the queue, then ALU is back-pressured
    vecs.push_back(mk(0,1,1,16'h0101, 1,2,16'h0202, 0,0, 0,0,16'h0000, 0,1,1, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,1,3,16'h0303, 1,4,16'h0404, 0,0, 1,1,16'h0101, 2,1,1, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,1,5,16'h0505, 1,6,16'h0606, 0,0, 1,2,16'h0202, 3,1,1, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,1,7,16'h0707, 1,8,16'h0808, 0,0, 1,3,16'h0303, 4,1,0, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,1,9,16'h0909, 1,8,16'h0808, 0,0, 1,4,16'h0404, 4,1,0, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000, 1,8,16'h0808, 0,0, 1,5,16'h0505, 4,1,1, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 8,9, 1,6,16'h0606, 4,1,1, 1,16'h0808, 1,16'h0909));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,0, 1,7,16'h0707, 3,1,1, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,0, 1,9,16'h0909, 2,1,1, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,0, 1,8,16'h0808, 1,1,1, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0,16'h0000, 0,1,1, 0,16'h0000, 0,16'h0000));
    // three entries queued, then reset with a load presented: all discarded
    vecs.push_back(mk(0,1,1,16'h1111, 1,2,16'h2222, 0,0, 0,0,16'h0000, 0,1,1, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,1,3,16'h3333, 1,4,16'h4444, 0,0, 1,1,16'h1111, 2,1,1, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(1,1,6,16'h6666, 0,0,16'h0000, 3,0, 1,2,16'h2222, 3,1,1, 1,16'h3333, 0,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 3,4, 0,0,16'h0000, 0,1,1, 0,16'h0000, 0,16'h0000));
    // youngest-match forwarding, miss returns zero
    vecs.push_back(mk(0,1,7,16'h0001, 1,7,16'h0002, 0,0, 0,0,16'h0000, 0,1,1, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 8,7, 1,7,16'h0001, 2,1,1, 0,16'h0000, 1,16'h0002));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,7, 1,7,16'h0002, 1,1,1, 0,16'h0000, 1,16'h0002));
    // register 0 is an ordinary index; same-cycle acceptance is not visible
    vecs.push_back(mk(0,1,0,16'hFFFF, 0,0,16'h0000, 0,0, 0,0,16'h0000, 0,1,1, 0,16'h0000, 0,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,5, 1,0,16'hFFFF, 1,1,1, 1,16'hFFFF, 0,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000, 0,0,16'h0000, 0,0, 0,0,16'h0000, 0,1,1, 0,16'h0000, 0,16'h0000));

    @(posedge clk);
    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      mem_valid = vecs[i].mv; mem_reg = vecs[i].mr; mem_data = vecs[i].md;
      alu_valid = vecs[i].av; alu_reg = vecs[i].ar; alu_data = vecs[i].ad;
      fwd_reg1 = vecs[i].f1; fwd_reg2 = vecs[i].f2;
      #1;
      check_outs($sformatf("row%0d", i), vecs[i].wr, vecs[i].dr, vecs[i].dd, vecs[i].cnt,
                 vecs[i].mrdy, vecs[i].ardy, vecs[i].h1, vecs[i].d1, vecs[i].h2, vecs[i].d2);
    end

    // Random mixed traffic; the table ended with an empty queue.
    mq.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        e_wr, e_mr, e_ar, e_h1, e_h2;
      logic [3:0]  e_dr;
      logic [15:0] e_dd, e_d1, e_d2;
      int          cnt, fr;
      @(negedge clk);
      rst       = ($urandom_range(0, 199) == 0);
      mem_valid = 1'($urandom_range(0, 1));
      alu_valid = 1'($urandom_range(0, 1));
      mem_reg   = 4'($urandom_range(0, 7));
      alu_reg   = 4'($urandom_range(0, 7));
      mem_data  = 16'($urandom);
      alu_data  = 16'($urandom);
      fwd_reg1  = 4'($urandom_range(0, 7));
      fwd_reg2  = 4'($urandom_range(0, 7));
      #1;
      cnt  = mq.size();
      fr   = 4 - cnt + ((cnt != 0) ? 1 : 0);
      e_mr = (fr >= 1);
      e_ar = (fr >= 1 + int'(mem_valid));
      e_wr = (cnt != 0);
      e_dr = e_wr ? mq[0].dst  : 4'h0;
      e_dd = e_wr ? mq[0].data : 16'h0;
      e_h1 = 0; e_d1 = 0; e_h2 = 0; e_d2 = 0;
      for (int k = 0; k < cnt; k++) begin
        if (mq[k].dst == fwd_reg1) begin e_h1 = 1; e_d1 = mq[k].data; end
        if (mq[k].dst == fwd_reg2) begin e_h2 = 1; e_d2 = mq[k].data; end
      end
      check_outs($sformatf("rand%0d", cyc), e_wr, e_dr, e_dd, 3'(cnt),
                 e_mr, e_ar, e_h1, e_d1, e_h2, e_d2);
      if (rst) mq.delete();
      else begin
        wb_entry_t e;
        if (cnt != 0) void'(mq.pop_front());
        if (mem_valid && e_mr) begin e.dst = mem_reg; e.data = mem_data; mq.push_back(e); end
        if (alu_valid && e_ar) begin e.dst = alu_reg; e.data = alu_data; mq.push_back(e); end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
